// File: rtl/ld_pkg.sv
// ----------------------------------------------------------------------------
// ld_pkg
// Shared definitions for the bit-serial subtractor.
//   state_e : controller state encoding (IDLE = 0, RUN = 1, DONE = 2)
//   cnt_width(): bits needed for a counter that must reach the value w
// ----------------------------------------------------------------------------
package ld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter has to hold WIDTH itself, not only WIDTH-1, so it never
  // wraps before the last serial step.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : ld_pkg

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor: computes a - b - bin.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor. An operand pair is accepted in IDLE, then
// processed LSB first through a single full subtractor over WIDTH RUN cycles.
// The result is presented in DONE until the consumer takes it.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand pair a/b valid
//   in_ready   : block accepts an operand pair (IDLE only)
//   a, b       : minuend / subtrahend, unsigned
//   out_valid  : result valid (DONE only)
//   out_ready  : consumer accepts result
//   diff       : (a - b) mod 2^WIDTH
//   borrow_out : 1 iff a < b
//   zero       : 1 iff diff == 0
// ----------------------------------------------------------------------------
module serial_subtractor
  import ld_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   res_q,    res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               bout_q,   bout_d;
  logic               zero_q,   zero_d;

  logic               fs_d;
  logic               fs_bout;
  logic [WIDTH-1:0]   res_shifted;
  logic               last_step;

  // Single shared bit-slice; always looks at the current operand LSBs.
  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Difference bits enter at the MSB end so after WIDTH shifts the first
  // (LSB) result bit has walked down to bit 0.
  assign res_shifted = {fs_d, res_q[WIDTH-1:1]};
  assign last_step   = (cnt_q == CNT_W'(WIDTH - 1));

  // Handshake outputs are pure decodes of the state register, so there is
  // no combinational path from in_valid or out_ready.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign zero       = zero_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d    = res_shifted;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          // Publish into separate output registers so the visible result
          // only changes when an operation completes.
          diff_d  = res_shifted;
          bout_d  = fs_bout;
          zero_d  = (res_shifted == '0);
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed test of serial_subtractor (WIDTH = 8) with hand-computed results.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;

  int n_checks;
  int n_errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: offer operands, scramble inputs during RUN,
  // measure latency, check result, optionally stall the consumer.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic [W-1:0] exp_d, input logic exp_bo,
                       input logic exp_z, input int hold);
    int cyc;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a         = op_a;
    b         = op_b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~op_a;
    b        = op_b ^ 8'h5C;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 4) begin
        a = 8'hFF;
        b = 8'h00;
      end
    end
    check("latency", 32'(cyc - 1), 32'(W));
    check("out_valid", 32'(out_valid), 32'd1);
    check("diff", 32'(diff), 32'(exp_d));
    check("borrow_out", 32'(borrow_out), 32'(exp_bo));
    check("zero", 32'(zero), 32'(exp_z));
    check("in_ready_done", 32'(in_ready), 32'd0);
    $display("op a=0x%02h b=0x%02h -> diff=0x%02h borrow=%0d zero=%0d cycles=%0d",
             op_a, op_b, diff, borrow_out, zero, cyc - 1);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a        = 8'h99;
      b        = 8'h11;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(exp_d));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 0);
    do_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0);
    do_op(8'h42, 8'h42, 8'h00, 1'b0, 1'b1, 0);
    do_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hC3, 8'h5A, 8'h69, 1'b0, 1'b0, 5);

    // Reset in the middle of RUN (4th RUN cycle) drops the operation.
    @(negedge clk);
    a        = 8'h77;
    b        = 8'h11;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_run_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    $display("reset pulsed mid-RUN: out_valid=%0d diff=0x%02h", out_valid, diff);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width (>=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand pair.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 SHALL have port borrow_out  output  1  final borrow; 1 iff a < b.
REQ-012 SHALL have port zero  output  1  1 iff diff == 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid & in_ready, capture a and b into shift registers, clear borrow flop and bit counter, enter RUN.
REQ-016 SHALL, each RUN cycle, feed LSBs of both shift registers and borrow flop into one full subtractor, shift diff bit into result register from MSB end, update borrow flop, shift operands right, increment counter.
REQ-017 SHALL leave RUN after exactly WIDTH RUN cycles; out_valid rises in the cycle after the WIDTH-th RUN edge (capture edge + WIDTH edges).
REQ-018 SHALL hold diff, borrow_out, zero stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL, in DONE on out_ready = 1, return to IDLE at that edge; no back-to-back accept in the same edge.
REQ-020 SHALL ignore in_valid, a, b outside IDLE; SHALL ignore out_ready outside DONE.
REQ-021 SHALL compute counter width as clog2(WIDTH+1); counter must not wrap before WIDTH.
REQ-022 SHALL produce a - b with a = b giving diff = 0, zero = 1, borrow_out = 0.

Reset
REQ-023 SHALL, on rst_n low at any time (incl. mid-RUN or DONE), immediately enter IDLE and drop in-flight operation.
REQ-024 SHALL reset values: in_ready = 1 after release, out_valid = 0, diff = 0, borrow_out = 0, zero = 0, counter = 0, borrow flop = 0.
REQ-025 SHALL accept a new operand on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place FSM state encodings (IDLE = 0, RUN = 1, DONE = 2, 2 bits) in shared package ld_pkg.
REQ-027 SHALL instantiate exactly one sub-module full_subtractor (inputs a, b, bin; outputs d = a^b^bin, bout = (~a&b) | (~a&bin) | (b&bin)).
REQ-028 SHALL contain no combinational path from in_valid to in_ready or out_ready to out_valid.

Verification (WIDTH = 8)
REQ-029 SHALL test a = 0x5A, b = 0x23 -> after 8 RUN cycles diff = 0x37, borrow_out = 0, zero = 0.
REQ-030 SHALL test a = 0x10, b = 0x20 -> diff = 0xF0, borrow_out = 1; and a = 0x00, b = 0xFF -> diff = 0x01, borrow_out = 1.
REQ-031 SHALL test a = 0x42, b = 0x42 -> diff = 0x00, zero = 1, borrow_out = 0.
REQ-032 SHALL test out_ready held 0 for 5 cycles in DONE -> out_valid and diff stable, in_ready = 0, new in_valid ignored; on out_ready = 1 next cycle in_ready = 1.
REQ-033 SHALL test rst_n pulsed low at RUN cycle 4 -> out_valid = 0, diff = 0 immediately; next operand pair 0x05 - 0x03 -> diff = 0x02.
REQ-034 SHALL test changing a/b during RUN -> result reflects captured operands only.
